ir_frame_decoder: RTL and testbench
===================================

// Module: ir_frame_decoder
// PURPOSE
//  Parametrised pulse-width IR frame decoder, clocked ~20x slower than the IR carrier (~2 kHz).
//  Measures each high pulse of irwave and classifies it as data 0, data 1 or start.
//  Assembles FRAME_BITS data bits after a start pulse into a frame; aborts on a mid-frame
//  restart or a low-gap timeout. Sits between the IR receiver pin and command-decode logic.
// PARAMETERS
//  FRAME_BITS  32  data bits per frame, received LSB first (>=1)
//  CNT_W       5   width of the high and low pulse counters; both saturate at 2^CNT_W-1
//  T1_MIN      3   min high count classified as data 1; below it = data 0
//  START_MIN   7   min high count classified as start; rule: 0<T1_MIN<START_MIN<=2^CNT_W-1
//  GAP_MAX     24  low count that times out a frame in progress (<=2^CNT_W-1)
//  FILT_LEN    2   glitch-filter stability length in cycles; used only with IR_FILTER_EN
// PORTS
//  clk          in   1           system clock (~2 kHz)
//  rst_n        in   1           asynchronous active-low reset
//  irwave       in   1           raw demodulated IR input, asynchronous to clk
//  bit_out      out  1           value of the most recent classified data bit
//  bit_valid    out  1           1-cycle strobe: bit_out updated
//  frame_data   out  FRAME_BITS  last complete frame; bit 0 = first bit received
//  frame_valid  out  1           1-cycle strobe: frame_data updated
//  frame_err    out  1           1-cycle strobe: partial frame aborted
//  busy         out  1           high while in DATA state
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; counters, shift register and bit index 0.
//    Reset assertion mid-frame discards the partial frame; no strobe is generated.
//  - irwave passes through a 2-flop synchroniser -> ir_s, then the optional filter -> ir_f.
//  - hi_cnt increments each cycle ir_f=1 (saturating). A falling edge (ir_f 1->0)
//    classifies hi_cnt: <T1_MIN -> 0, T1_MIN..START_MIN-1 -> 1, >=START_MIN -> start.
//    hi_cnt clears on that edge.
//  - lo_cnt increments each cycle ir_f=0 (saturating). It clears while ir_f=1.
//  - Outputs register on the classifying edge. Without the filter, total latency is 3 clk
//    edges from an irwave fall to a strobe.
//  - FSM IDLE:
//    - start -> DATA, bit index=0, shift register cleared.
//    - data bits are ignored, with no bit_valid.
//  - FSM DATA:
//    - Each data bit shifts in and pulses bit_valid.
//    - On bit FRAME_BITS-1, frame_data <= assembled word, frame_valid=1, -> IDLE.
//    - start in DATA: frame_err=1, partial data dropped, stay DATA, index=0 (resync).
//    - lo_cnt reaches GAP_MAX in DATA: frame_err=1, -> IDLE.
//  - Frame completion and a timeout in the same cycle cannot both occur: a bit needs a
//    falling edge, which clears lo_cnt.
//  - frame_valid and frame_err are never high together. frame_data holds until the next
//    valid frame.
//  - Saturated hi_cnt (stuck-high input) still classifies as start on release.
// CONFIGURATION
//  IR_FILTER_EN defined:
//    - ir_f takes a new ir_s value only after FILT_LEN consecutive equal samples.
//    - Pulses shorter than FILT_LEN cycles are removed.
//    - Latency grows by FILT_LEN cycles; measured widths are unchanged.
//  IR_FILTER_EN undefined: ir_f = ir_s; FILT_LEN is ignored.
// TESTING
//  1. rst_n low with irwave toggling -> all outputs 0.
//     Release rst_n with irwave low -> no strobes.
//  2. FRAME_BITS=8. Start (10 high), then highs of 1,4,1,1,4,4,1,4, lows of 2 ->
//     8 bit_valid strobes, frame_data=8'hB2, one frame_valid, busy 0 after.
//  3. Default config, highs of 2 / 3 / 6 / 7 / 40 cycles -> classified 0 / 1 / 1 / start / start
//     (40 saturates at 31).
//  4. FRAME_BITS=8. Start, 3 data bits, then a start, then 8 bits for 8'h5A ->
//     frame_err once, then frame_valid with 8'h5A.
//  5. Start, 2 bits, then irwave low 30 cycles -> frame_err on the cycle lo_cnt=24, busy 0,
//     frame_data unchanged.
//  6. IR_FILTER_EN, FILT_LEN=2. 1-cycle high glitches inside a valid frame -> frame decodes
//     unchanged. Same stimulus without the macro -> corrupted frame.

Source files
------------

// File: rtl/ir_frame_decoder.sv
// Pulse-width IR frame decoder: classifies high pulses as data 0 / data 1 / start and assembles frames.
// Optional glitch filter on the synchronised input is enabled with `define IR_FILTER_EN.
//   state | meaning
//   IDLE  | waiting for a start pulse, data pulses ignored
//   DATA  | collecting FRAME_BITS data bits after a start pulse
module ir_frame_decoder #(
    parameter int FRAME_BITS = 32,
    parameter int CNT_W      = 5,
    parameter int T1_MIN     = 3,
    parameter int START_MIN  = 7,
    parameter int GAP_MAX    = 24,
    parameter int FILT_LEN   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  irwave,
    output logic                  bit_out,
    output logic                  bit_valid,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int IDX_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] T1_C    = CNT_W'(T1_MIN);
    localparam logic [CNT_W-1:0] START_C = CNT_W'(START_MIN);
    localparam logic [CNT_W-1:0] GAP_PRE = CNT_W'(GAP_MAX - 1);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(FRAME_BITS - 1);

    if (FRAME_BITS < 1 || T1_MIN < 1 || START_MIN <= T1_MIN || START_MIN > (2**CNT_W) - 1 ||
        GAP_MAX < 1 || GAP_MAX > (2**CNT_W) - 1 || FILT_LEN < 1) begin : g_bad_params
        $error("ir_frame_decoder: illegal parameter combination");
    end

    typedef enum logic {IDLE, DATA} state_t;

    state_t                state, state_nx;
    logic                  ir_m, ir_s, ir_f, ir_q;
    logic [CNT_W-1:0]      hi_cnt, lo_cnt;
    logic [IDX_W-1:0]      idx, idx_nx;
    logic [FRAME_BITS-1:0] shreg, shreg_nx, frame_data_nx;
    logic                  bit_out_nx, bit_valid_nx, frame_valid_nx, frame_err_nx;
    logic                  fall, is_start, is_data, data_bit, timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_m <= 1'b0;
            ir_s <= 1'b0;
            ir_q <= 1'b0;
        end else begin
            ir_m <= irwave;
            ir_s <= ir_m;
            ir_q <= ir_f;
        end
    end

`ifdef IR_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN + 1);
    logic [FC_W-1:0] filt_cnt;
    logic            ir_fr;

    // ir_fr follows ir_s only once the new level has been seen FILT_LEN times in a row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= '0;
            ir_fr    <= 1'b0;
        end else if (ir_s == ir_fr) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
            filt_cnt <= '0;
            ir_fr    <= ir_s;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign ir_f = ir_fr;
`else
    assign ir_f = ir_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else if (ir_f) begin
            if (hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + 1'b1;
            lo_cnt <= '0;
        end else begin
            hi_cnt <= '0;
            if (lo_cnt != CNT_MAX) lo_cnt <= lo_cnt + 1'b1;
        end
    end

    assign fall     = ir_q & ~ir_f;
    assign is_start = fall && (hi_cnt >= START_C);
    assign is_data  = fall && !is_start;
    assign data_bit = (hi_cnt >= T1_C);
    // fires on the edge that takes lo_cnt to GAP_MAX
    assign timeout  = !ir_f && (lo_cnt == GAP_PRE);
    assign busy     = (state == DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (is_start) state_nx = DATA;
            DATA: begin
                if (is_data && idx == LAST)  state_nx = IDLE;
                else if (!fall && timeout)   state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bit_out_nx     = bit_out;
        bit_valid_nx   = 1'b0;
        frame_valid_nx = 1'b0;
        frame_err_nx   = 1'b0;
        idx_nx         = idx;
        shreg_nx       = shreg;
        frame_data_nx  = frame_data;
        case (state)
            IDLE: begin
                if (is_start) begin
                    idx_nx   = '0;
                    shreg_nx = '0;
                end
            end
            DATA: begin
                if (is_start) begin
                    frame_err_nx = 1'b1;
                    idx_nx       = '0;
                    shreg_nx     = '0;
                end else if (is_data) begin
                    bit_valid_nx  = 1'b1;
                    bit_out_nx    = data_bit;
                    shreg_nx[idx] = data_bit;
                    if (idx == LAST) begin
                        frame_data_nx  = shreg_nx;
                        frame_valid_nx = 1'b1;
                        idx_nx         = '0;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end else if (timeout) begin
                    frame_err_nx = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_data  <= '0;
            shreg       <= '0;
            idx         <= '0;
        end else begin
            bit_out     <= bit_out_nx;
            bit_valid   <= bit_valid_nx;
            frame_valid <= frame_valid_nx;
            frame_err   <= frame_err_nx;
            frame_data  <= frame_data_nx;
            shreg       <= shreg_nx;
            idx         <= idx_nx;
        end
    end

endmodule

// File: tb/tb_ir_frame_decoder.sv
// Scoreboard bench for ir_frame_decoder: a pulse-level model queues expected strobes with their cycle.
module tb_ir_frame_decoder;

    localparam int FB        = 8;
    localparam int CNT_W     = 5;
    localparam int T1_MIN    = 3;
    localparam int START_MIN = 7;
    localparam int GAP_MAX   = 24;
    localparam int FILT_LEN  = 2;
    localparam int SAT       = (1 << CNT_W) - 1;
`ifdef IR_FILTER_EN
    localparam int FILT_LAT  = FILT_LEN;
    localparam bit FILT_ON   = 1'b1;
`else
    localparam int FILT_LAT  = 0;
    localparam bit FILT_ON   = 1'b0;
`endif
    localparam int K_BIT = 0, K_FRM = 1, K_ERR = 2;

    typedef struct {
        int          kind;
        logic [FB-1:0] val;
        int          t;
    } ev_t;

    ev_t sb[$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          irwave = 1'b0;
    logic          bit_out, bit_valid, frame_valid, frame_err, busy;
    logic [FB-1:0] frame_data;

    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    bit  mon_en = 1'b0;

    bit            m_data = 1'b0;
    int            m_idx = 0;
    logic [FB-1:0] m_word = '0;
    logic [FB-1:0] m_last = '0;

    ir_frame_decoder #(
        .FRAME_BITS(FB), .CNT_W(CNT_W), .T1_MIN(T1_MIN), .START_MIN(START_MIN),
        .GAP_MAX(GAP_MAX), .FILT_LEN(FILT_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .irwave(irwave),
        .bit_out(bit_out), .bit_valid(bit_valid), .frame_data(frame_data),
        .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int k, input logic [FB-1:0] v, input int t);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.t    = t;
        sb.push_back(e);
    endtask

    // p is the cycle count at which irwave was driven low after the high pulse
    task automatic model_pulse(input int hi, input int p);
        int   h;
        int   t;
        logic b;
        if (FILT_ON && hi < FILT_LEN) return;
        h = (hi > SAT) ? SAT : hi;
        t = p + 3 + FILT_LAT;
        if (h >= START_MIN) begin
            if (m_data) push(K_ERR, '0, t);
            m_data = 1'b1;
            m_idx  = 0;
            m_word = '0;
        end else if (m_data) begin
            b = (h >= T1_MIN);
            m_word[m_idx] = b;
            push(K_BIT, FB'(b), t);
            if (m_idx == FB - 1) begin
                m_last = m_word;
                push(K_FRM, m_word, t);
                m_data = 1'b0;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic send_pulse(input int hi, input int lo);
        int p;
        irwave = 1'b1;
        repeat (hi) @(negedge clk);
        irwave = 1'b0;
        p = cyc;
        model_pulse(hi, p);
        if (m_data && lo >= GAP_MAX) begin
            push(K_ERR, '0, p + 2 + GAP_MAX + FILT_LAT);
            m_data = 1'b0;
        end
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_bits(input logic [FB-1:0] w, input int n, input int zero_w);
        for (int i = 0; i < n; i++) send_pulse(w[i] ? 4 : zero_w, 2);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        if (sb.size() != 0) sb.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic take(input int k, input logic [FB-1:0] v);
        ev_t e;
        if (sb.size() == 0) begin
            chk("unexpected_strobe_kind_plus1", k + 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("strobe_kind", k, e.kind);
        chk("strobe_cycle", cyc, e.t);
        if (k != K_ERR) chk("strobe_value", 32'(v), 32'(e.val));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bit_valid)   take(K_BIT, FB'(bit_out));
            if (frame_valid) take(K_FRM, frame_data);
            if (frame_err)   take(K_ERR, '0);
            if (frame_valid || frame_err)
                chk("valid_err_exclusive", 32'(frame_valid & frame_err), 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

    initial begin
        logic [FB-1:0] w;

        // reset held with the input toggling
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            irwave = ~irwave;
            chk("reset_strobes", 32'({bit_out, bit_valid, frame_valid, frame_err, busy}), 0);
            chk("reset_frame_data", 32'(frame_data), 0);
        end
        irwave = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        // basic 8-bit frame 0xB2
        send_pulse(10, 3 + FILT_LAT);
        chk("busy_after_start", 32'(busy), 1);
        send_bits(8'hB2, 8, 1);
        drain();
        chk("busy_after_frame", 32'(busy), 32'(m_data));
        chk("frame_b2", 32'(frame_data), FILT_ON ? 32'(m_last) : 32'hB2);

        // classification boundaries, restart and saturated start, then timeout
        send_pulse(10, 2);
        send_pulse(2, 2);
        send_pulse(3, 2);
        send_pulse(6, 2);
        send_pulse(7, 2);
        send_pulse(40, 30);
        drain();
        chk("busy_after_gap", 32'(busy), 0);

        // mid-frame restart then a clean 0x5A frame
        send_pulse(10, 2);
        send_bits(8'h05, 3, 2);
        send_pulse(10, 2);
        send_bits(8'h5A, 8, 2);
        drain();
        chk("frame_5a", 32'(frame_data), 32'h5A);

        // two bits then a long low gap
        send_pulse(10, 2);
        send_pulse(2, 2);
        send_pulse(4, 30);
        drain();
        chk("busy_after_timeout", 32'(busy), 0);
        chk("frame_kept_after_timeout", 32'(frame_data), 32'h5A);

        // one-cycle glitches inside the low gaps of a 0xA5 frame
        w = 8'hA5;
        send_pulse(10, 2);
        for (int i = 0; i < 8; i++) begin
            send_pulse(w[i] ? 4 : 2, 2);
            if (i == 1 || i == 4) send_pulse(1, 2);
        end
        repeat (30) @(negedge clk);
        drain();
        chk("glitch_frame", 32'(frame_data), FILT_ON ? 32'hA5 : 32'h89);
        chk("busy_end", 32'(busy), 32'(m_data));

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
